// File: rtl/wb_spi_channel_bridge.sv
// wb_spi_channel_bridge: classic-cycle Wishbone bridge fanning one upstream master out to
// NUM_CH SPI-master WB slaves. The channel comes from the top CH_W address bits. Index NUM_CH
// selects a local register page (MASK / STATUS / TOUTCNT), and any higher index is a decode error.
// Each downstream access has an ack timeout. Interrupts are aggregated as masked, sticky bits.
// Optional build macro: WB_SPI_BRIDGE_RETRY_EN. When it is defined, a timeout answers with
// s_rty_o instead of s_err_o.

// Per-channel interrupt cell: mask bit plus sticky status bit
module wb_spi_ch_irq (
    input  logic clk,
    input  logic rst,
    input  logic inta,
    input  logic mask_we,
    input  logic mask_d,
    input  logic clr,
    output logic mask_q,
    output logic stat_q
);
    // mask bit, plain read/write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mask_q <= 1'b0;
        else if (mask_we) mask_q <= mask_d;
    end

    // status bit: a live interrupt beats a same-cycle write-1-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_q <= 1'b0;
        else     stat_q <= inta | (stat_q & ~clr);
    end
endmodule

module wb_spi_channel_bridge #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     s_cyc_i,
    input  logic                     s_stb_i,
    input  logic                     s_we_i,
    input  logic [ADDR_W-1:0]        s_adr_i,
    input  logic [DATA_W-1:0]        s_dat_i,
    output logic [DATA_W-1:0]        s_dat_o,
    output logic                     s_ack_o,
    output logic                     s_err_o,
    output logic                     s_rty_o,
    output logic [NUM_CH-1:0]        m_cyc_o,
    output logic [NUM_CH-1:0]        m_stb_o,
    output logic                     m_we_o,
    output logic [ADDR_W-1:0]        m_adr_o,
    output logic [DATA_W-1:0]        m_dat_o,
    input  logic [NUM_CH*DATA_W-1:0] m_dat_i,
    input  logic [NUM_CH-1:0]        m_ack_i,
    input  logic [NUM_CH-1:0]        ch_inta_i,
    output logic                     irq_o
);
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int OFF_W = ADDR_W - CH_W;
    localparam int TC_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;
    typedef enum logic [1:0] {R_ACK, R_ERR, R_RTY} resp_t;

`ifdef WB_SPI_BRIDGE_RETRY_EN
    localparam resp_t TOUT_RESP = R_RTY;
`else
    localparam resp_t TOUT_RESP = R_ERR;
`endif

    state_t              state_q, state_d;
    resp_t               resp_q, resp_d;
    logic                start, loc, cap, tout;
    logic                we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q, rdata_q, loc_rd, dat_sel;
    logic [CH_W-1:0]     ch_q, req_idx;
    logic [OFF_W-1:0]    req_off;
    logic [TC_W-1:0]     tcnt_q;
    logic [7:0]          toutcnt_q;
    logic                ack_sel, irq_q;
    logic [NUM_CH-1:0]   mask_q, stat_q, sel;
    logic [DATA_W-1:0]   mask_ext, stat_ext, tout_ext;
    logic                mask_we, stat_clr_en;

    assign req_idx = s_adr_i[ADDR_W-1 -: CH_W];
    assign req_off = s_adr_i[OFF_W-1:0];

    // state and response-kind register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            resp_q  <= R_ACK;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    // next-state decode plus one-cycle datapath enables
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        start   = 1'b0;
        loc     = 1'b0;
        cap     = 1'b0;
        tout    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    start = 1'b1;
                    if (req_idx < CH_W'(NUM_CH)) begin
                        state_d = S_REQ;
                    end else if (req_idx == CH_W'(NUM_CH)) begin
                        loc     = 1'b1;
                        resp_d  = R_ACK;
                        state_d = S_RESP;
                    end else begin
                        resp_d  = R_ERR;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ: begin
                if (!s_cyc_i) begin
                    state_d = S_IDLE;
                end else if (ack_sel) begin
                    cap     = 1'b1;
                    resp_d  = R_ACK;
                    state_d = S_RESP;
                end else if (tcnt_q == TC_W'(TIMEOUT - 1)) begin
                    tout    = 1'b1;
                    resp_d  = TOUT_RESP;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_HOLD;
            S_HOLD: if (!s_stb_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // select the addressed channel's ack and read data, and build the one-hot strobe
    always_comb begin
        ack_sel = 1'b0;
        dat_sel = '0;
        sel     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                ack_sel = m_ack_i[i];
                dat_sel = m_dat_i[i*DATA_W +: DATA_W];
                sel[i]  = (state_q == S_REQ);
            end
        end
    end

    // request latch and read-data capture; read data stays 0 for writes and errors
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ch_q    <= '0;
            rdata_q <= '0;
        end else if (start) begin
            we_q    <= s_we_i;
            adr_q   <= {{CH_W{1'b0}}, req_off};
            dat_q   <= s_dat_i;
            ch_q    <= req_idx;
            rdata_q <= (loc && !s_we_i) ? loc_rd : '0;
        end else if (cap) begin
            rdata_q <= we_q ? '0 : dat_sel;
        end
    end

    // per-access cycle counter, restarts whenever not in REQ
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)               tcnt_q <= '0;
        else if (state_q == S_REQ)  tcnt_q <= tcnt_q + TC_W'(1);
        else                        tcnt_q <= '0;
    end

    // saturating timeout counter; any local write to offset 2 clears it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            toutcnt_q <= '0;
        else if (tout && toutcnt_q != 8'hFF)
            toutcnt_q <= toutcnt_q + 8'd1;
        else if (start && loc && s_we_i && req_off == OFF_W'(2))
            toutcnt_q <= '0;
    end

    assign mask_we     = start && loc && s_we_i && (req_off == OFF_W'(0));
    assign stat_clr_en = start && loc && s_we_i && (req_off == OFF_W'(1));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wbit;
        if (i < DATA_W) begin : g_b
            assign wbit = s_dat_i[i];
        end else begin : g_z
            assign wbit = 1'b0;
        end
        wb_spi_ch_irq u_irq (
            .clk     (wb_clk_i),
            .rst     (wb_rst_i),
            .inta    (ch_inta_i[i]),
            .mask_we (mask_we),
            .mask_d  (wbit),
            .clr     (stat_clr_en & wbit),
            .mask_q  (mask_q[i]),
            .stat_q  (stat_q[i])
        );
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_rd
        if (b < NUM_CH) begin : g_c
            assign mask_ext[b] = mask_q[b];
            assign stat_ext[b] = stat_q[b];
        end else begin : g_cz
            assign mask_ext[b] = 1'b0;
            assign stat_ext[b] = 1'b0;
        end
        if (b < 8) begin : g_t
            assign tout_ext[b] = toutcnt_q[b];
        end else begin : g_tz
            assign tout_ext[b] = 1'b0;
        end
    end

    // local page read mux
    always_comb begin
        loc_rd = '0;
        case (req_off)
            OFF_W'(0): loc_rd = mask_ext;
            OFF_W'(1): loc_rd = stat_ext;
            OFF_W'(2): loc_rd = tout_ext;
            default:   loc_rd = '0;
        endcase
    end

    // aggregated interrupt, one cycle behind status/mask
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq_q <= 1'b0;
        else          irq_q <= |(stat_q & mask_q);
    end

    assign irq_o   = irq_q;
    assign s_ack_o = (state_q == S_RESP) && (resp_q == R_ACK);
    assign s_err_o = (state_q == S_RESP) && (resp_q == R_ERR);
`ifdef WB_SPI_BRIDGE_RETRY_EN
    assign s_rty_o = (state_q == S_RESP) && (resp_q == R_RTY);
`else
    assign s_rty_o = 1'b0;
`endif
    assign s_dat_o = s_ack_o ? rdata_q : '0;
    assign m_cyc_o = sel;
    assign m_stb_o = sel;
    assign m_we_o  = we_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;
endmodule
